hazard_info_pipe: RTL and testbench
===================================

Name: hazard_info_pipe

Overview:
- Carries hazard bookkeeping for each instruction from the D/E boundary through E/M and M/W.
- Per instruction it carries: source/destination register numbers, register-write enable, Tnew countdown, instruction word and PC.
- Decodes A3/RegWr/Tnew from the D-stage instruction word.
- Registered outputs (A1_E, A2_E, A3_E/M/W, RegWr_E/M/W, Tnew_E/M, A2_M) feed the forwarding unit and stall logic directly.

Parameters:
- WIDTH, 32, datapath/instruction width.
- RA_REG, 31, destination register number for jal.
- TNEW_LOAD, 2, Tnew at E entry for loads.
- TNEW_ALU, 1, Tnew at E entry for ALU/lui results.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- instr_D  in  32  D-stage instruction word
- pc_D  in  32  D-stage PC
- stall  in  1  from stall logic; E stage receives a bubble this cycle
- flush_E  in  1  squash instruction entering E (independent of stall)
- instr_E, instr_M, instr_W  out  32  staged instruction words
- pc8_E, pc8_M, pc8_W  out  32  staged PC+8 (jal link value)
- A1_E, A2_E  out  5  rs/rt of E instruction
- A2_M  out  5  rt of M instruction
- A3_E, A3_M, A3_W  out  5  destination register per stage
- RegWr_E, RegWr_M, RegWr_W  out  1  register-write enable per stage
- Tnew_E, Tnew_M  out  2  cycles until result is available in pipeline

Behaviour:
- Reset: clk and reset are as decided; reset is asynchronous, active-high. All outputs clear to 0, including instr/pc8 fields; the pipeline holds bubbles (A3=0, RegWr=0, Tnew=0).
- Decode, combinational on instr_D:
  - addu/subu (op 0, funct 21h/23h): A3=rd, RegWr=1, Tnew=TNEW_ALU.
  - ori/lui: A3=rt, RegWr=1, Tnew=TNEW_ALU.
  - lw: A3=rt, RegWr=1, Tnew=TNEW_LOAD.
  - jal: A3=RA_REG, RegWr=1, Tnew=0.
  - sw/beq/j/jr/nop/unknown: A3=0, RegWr=0, Tnew=0.
  - A decoded A3 of 0 forces RegWr=0.
- D->E, each posedge:
  - If stall or flush_E, E loads a bubble (all fields 0).
  - Otherwise E loads the decode of instr_D; A1_E=instr_D[25:21], A2_E=instr_D[20:16], pc8_E=pc_D+8 (mod 2^32).
- E->M and M->W advance unconditionally every cycle; stall never freezes E/M or M/W.
- Tnew countdown: Tnew_M = (Tnew_E==0) ? 0 : Tnew_E-1; saturates, never wraps. Tnew is not carried to W (implicitly 0).
- A3, RegWr, instr, pc8 shift unchanged E->M->W; A2_M = A2_E of the previous cycle.
- Simultaneous stall and flush_E: single bubble, same as either alone.
- Reset asserted mid-stream clears all stages immediately; the first post-reset capture is the current instr_D unless stall is high.
- Latency: D decode visible on *_E one cycle later, *_M two, *_W three.

Optional Feature:
- Macro LOAD_EXT_EN.
- Defined: lb/lbu/lh/lhu (op 20h/24h/21h/25h) decode as loads (A3=rt, RegWr=1, Tnew=TNEW_LOAD); sb/sh (28h/29h) decode as no-write.
- Undefined: these opcodes decode as unknown (RegWr=0, A3=0, Tnew=0).

Decomposition:
- Shared header: opcode/funct constants (OP_RTYPE, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, FUNCT_ADDU, FUNCT_SUBU, FUNCT_JR, load-ext opcodes), TNEW widths, bubble value.
- Sub-module hazard_decode: the combinational instr -> {A3, RegWr, Tnew} decoder, reusable by stall logic for Tuse/Tnew comparison.

Test Plan:
- Reset mid-run with lw in E and M: all outputs 0 asynchronously, before the next clock edge.
- lw $8,0($9) in D, no stall:
  - cycle+1: A3_E=8, RegWr_E=1, Tnew_E=2, A1_E=9.
  - +2: A3_M=8, Tnew_M=1.
  - +3: A3_W=8, RegWr_W=1.
- addu $3,$1,$2 followed by stall=1 for one cycle: the E stage in the stalled cycle shows a bubble (A3_E=0, RegWr_E=0, Tnew_E=0) while the addu ahead continues to M with Tnew_M=0.
- jal at pc_D=0x00003000: pc8_E=0x00003008, A3_E=31, Tnew_E=0; pc8_W=0x00003008 two cycles later.
- ori $0,$1,5: RegWr_E=0, A3_E=0. pc_D=0xFFFFFFFC gives pc8_E=0x00000004.
- With LOAD_EXT_EN, lb $5,0($6): A3_E=5, Tnew_E=2. Without it: RegWr_E=0.

Source files
------------

// File: rtl/hazard_info_pipe_pkg.sv
// hazard_info_pipe_pkg: shared constants and types for the hazard bookkeeping pipe.
//   - MIPS opcode/funct encodings recognised by the hazard decoder
//   - register-number and Tnew widths, per-stage hazard record and its bubble value
//   - saturating Tnew countdown helper
// Optional feature macro: LOAD_EXT_EN (byte/half loads and stores, see hazard_decode).
package hazard_info_pipe_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned TNEW_W = 2;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // Byte/half memory opcodes, only decoded when LOAD_EXT_EN is defined
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;

    // Which instruction field names the destination register
    typedef enum logic [1:0] {
        DstNone,
        DstRd,
        DstRt,
        DstRa
    } dst_sel_e;

    // Hazard record carried per stage
    typedef struct packed {
        logic [REG_W-1:0]  a1;
        logic [REG_W-1:0]  a2;
        logic [REG_W-1:0]  a3;
        logic              reg_wr;
        logic [TNEW_W-1:0] tnew;
    } hz_info_t;

    localparam hz_info_t HZ_BUBBLE = '0;

    // One stage of Tnew countdown; saturates at zero
    function automatic logic [TNEW_W-1:0] tnew_step(input logic [TNEW_W-1:0] tnew);
        return (tnew == '0) ? '0 : tnew - TNEW_W'(1);
    endfunction

endpackage

// File: rtl/hazard_info_pipe_if.sv
// hazard_info_pipe_if: bundle between the D stage / hazard unit and hazard_info_pipe.
//   master side drives: instr_D, pc_D, stall, flush_E
//   slave side (the pipe) drives: instr_E/M/W, pc8_E/M/W, A1_E, A2_E, A2_M,
//     A3_E/M/W, RegWr_E/M/W, Tnew_E/M
// Parameter WIDTH: datapath/instruction width (the decoder uses instr[31:0]).
interface hazard_info_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    // D-stage inputs
    logic [WIDTH-1:0] instr_D;
    logic [WIDTH-1:0] pc_D;
    logic             stall;
    logic             flush_E;

    // Staged instruction words and link values
    logic [WIDTH-1:0] instr_E;
    logic [WIDTH-1:0] instr_M;
    logic [WIDTH-1:0] instr_W;
    logic [WIDTH-1:0] pc8_E;
    logic [WIDTH-1:0] pc8_M;
    logic [WIDTH-1:0] pc8_W;

    // Hazard bookkeeping
    logic [4:0] A1_E;
    logic [4:0] A2_E;
    logic [4:0] A2_M;
    logic [4:0] A3_E;
    logic [4:0] A3_M;
    logic [4:0] A3_W;
    logic       RegWr_E;
    logic       RegWr_M;
    logic       RegWr_W;
    logic [1:0] Tnew_E;
    logic [1:0] Tnew_M;

    modport master (
        output instr_D, pc_D, stall, flush_E,
        input  instr_E, instr_M, instr_W, pc8_E, pc8_M, pc8_W,
        input  A1_E, A2_E, A2_M, A3_E, A3_M, A3_W,
        input  RegWr_E, RegWr_M, RegWr_W, Tnew_E, Tnew_M
    );

    modport slave (
        input  instr_D, pc_D, stall, flush_E,
        output instr_E, instr_M, instr_W, pc8_E, pc8_M, pc8_W,
        output A1_E, A2_E, A2_M, A3_E, A3_M, A3_W,
        output RegWr_E, RegWr_M, RegWr_W, Tnew_E, Tnew_M
    );

endinterface

// File: rtl/hazard_info_pipe_decode.sv
// hazard_decode: combinational instruction -> {A3, RegWr, Tnew} decoder.
//   instr  in  32  instruction word
//   a3     out 5   destination register (0 when the instruction writes nothing)
//   reg_wr out 1   register-write enable (never set when a3 is 0)
//   tnew   out 2   cycles from E entry until the result exists in the pipe
// Macro LOAD_EXT_EN: when defined, lb/lbu/lh/lhu decode as loads and sb/sh as
// no-write; when undefined those opcodes fall into the unknown (no-write) class.
module hazard_decode
    import hazard_info_pipe_pkg::*;
#(
    parameter int unsigned RA_REG    = 31,
    parameter int unsigned TNEW_LOAD = 2,
    parameter int unsigned TNEW_ALU  = 1
) (
    input  logic [31:0]       instr,
    output logic [REG_W-1:0]  a3,
    output logic              reg_wr,
    output logic [TNEW_W-1:0] tnew
);

    localparam logic [REG_W-1:0]  RaReg    = RA_REG[REG_W-1:0];
    localparam logic [TNEW_W-1:0] TnewLoad = TNEW_LOAD[TNEW_W-1:0];
    localparam logic [TNEW_W-1:0] TnewAlu  = TNEW_ALU[TNEW_W-1:0];

    logic [5:0]       op;
    logic [5:0]       funct;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    dst_sel_e         dst_sel;
    logic             unused_fields;

    assign op    = instr[31:26];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign funct = instr[5:0];

    // rs and shamt play no part in the destination decode
    assign unused_fields = ^{instr[25:21], instr[10:6]};

    always_comb begin
        dst_sel = DstNone;
        tnew    = '0;
        case (op)
            OP_RTYPE: begin
                if (funct == FUNCT_ADDU || funct == FUNCT_SUBU) begin
                    dst_sel = DstRd;
                    tnew    = TnewAlu;
                end
                // jr and unknown functs write nothing
            end
            OP_ORI, OP_LUI: begin
                dst_sel = DstRt;
                tnew    = TnewAlu;
            end
            OP_LW: begin
                dst_sel = DstRt;
                tnew    = TnewLoad;
            end
`ifdef LOAD_EXT_EN
            OP_LB, OP_LBU, OP_LH, OP_LHU: begin
                dst_sel = DstRt;
                tnew    = TnewLoad;
            end
            OP_SB, OP_SH: begin
                dst_sel = DstNone;
            end
`endif
            OP_JAL: begin
                // link value is pc+8, already known at E entry
                dst_sel = DstRa;
            end
            default: begin
                // sw, beq, j and unknown opcodes
                dst_sel = DstNone;
            end
        endcase
    end

    always_comb begin
        a3 = '0;
        unique case (dst_sel)
            DstRd:   a3 = rd;
            DstRt:   a3 = rt;
            DstRa:   a3 = RaReg;
            default: a3 = '0;
        endcase
    end

    // Writes to $0 are discarded, so they never create a hazard
    assign reg_wr = (dst_sel != DstNone) && (a3 != '0);

endmodule

// File: rtl/hazard_info_pipe.sv
// hazard_info_pipe: per-instruction hazard bookkeeping from D/E through E/M and M/W.
//   clk    in  system clock
//   reset  in  asynchronous, active-high reset; clears every stage to a bubble
//   bus    hazard_info_pipe_if.slave
//          in : instr_D, pc_D, stall, flush_E
//          out: instr/pc8 per stage, A1_E, A2_E, A2_M, A3/RegWr per stage, Tnew_E/M
// The D->E register loads a bubble on stall or flush_E; E/M and M/W always advance.
// Macro LOAD_EXT_EN is passed through to hazard_decode (byte/half loads).
module hazard_info_pipe
    import hazard_info_pipe_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RA_REG    = 31,
    parameter int unsigned TNEW_LOAD = 2,
    parameter int unsigned TNEW_ALU  = 1
) (
    input logic               clk,
    input logic               reset,
    hazard_info_pipe_if.slave bus
);

    logic [REG_W-1:0]  dec_a3;
    logic              dec_reg_wr;
    logic [TNEW_W-1:0] dec_tnew;

    hazard_decode #(
        .RA_REG   (RA_REG),
        .TNEW_LOAD(TNEW_LOAD),
        .TNEW_ALU (TNEW_ALU)
    ) u_decode (
        .instr (bus.instr_D[31:0]),
        .a3    (dec_a3),
        .reg_wr(dec_reg_wr),
        .tnew  (dec_tnew)
    );

    hz_info_t         info_e_d, info_e_q;
    hz_info_t         info_m_d, info_m_q;
    hz_info_t         info_w_q;
    logic [WIDTH-1:0] instr_e_d, instr_e_q, instr_m_q, instr_w_q;
    logic [WIDTH-1:0] pc8_e_d, pc8_e_q, pc8_m_q, pc8_w_q;
    logic             bubble_e;

    assign bubble_e = bus.stall || bus.flush_E;

    // D->E capture: decoded record, or an all-zero bubble
    always_comb begin
        info_e_d  = HZ_BUBBLE;
        instr_e_d = '0;
        pc8_e_d   = '0;
        if (!bubble_e) begin
            info_e_d.a1     = bus.instr_D[25:21];
            info_e_d.a2     = bus.instr_D[20:16];
            info_e_d.a3     = dec_a3;
            info_e_d.reg_wr = dec_reg_wr;
            info_e_d.tnew   = dec_tnew;
            instr_e_d       = bus.instr_D;
            pc8_e_d         = bus.pc_D + WIDTH'(8);
        end
    end

    // E->M: everything shifts, Tnew counts down by one stage
    always_comb begin
        info_m_d      = info_e_q;
        info_m_d.tnew = tnew_step(info_e_q.tnew);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            info_e_q  <= HZ_BUBBLE;
            info_m_q  <= HZ_BUBBLE;
            info_w_q  <= HZ_BUBBLE;
            instr_e_q <= '0;
            instr_m_q <= '0;
            instr_w_q <= '0;
            pc8_e_q   <= '0;
            pc8_m_q   <= '0;
            pc8_w_q   <= '0;
        end else begin
            info_e_q  <= info_e_d;
            info_m_q  <= info_m_d;
            info_w_q  <= info_m_q;
            instr_e_q <= instr_e_d;
            instr_m_q <= instr_e_q;
            instr_w_q <= instr_m_q;
            pc8_e_q   <= pc8_e_d;
            pc8_m_q   <= pc8_e_q;
            pc8_w_q   <= pc8_m_q;
        end
    end

    // Only the fields consumed downstream are exported from M and W
    logic unused_stage_bits;
    assign unused_stage_bits = ^{info_m_q.a1, info_w_q.a1, info_w_q.a2, info_w_q.tnew};

    assign bus.instr_E = instr_e_q;
    assign bus.instr_M = instr_m_q;
    assign bus.instr_W = instr_w_q;
    assign bus.pc8_E   = pc8_e_q;
    assign bus.pc8_M   = pc8_m_q;
    assign bus.pc8_W   = pc8_w_q;
    assign bus.A1_E    = info_e_q.a1;
    assign bus.A2_E    = info_e_q.a2;
    assign bus.A2_M    = info_m_q.a2;
    assign bus.A3_E    = info_e_q.a3;
    assign bus.A3_M    = info_m_q.a3;
    assign bus.A3_W    = info_w_q.a3;
    assign bus.RegWr_E = info_e_q.reg_wr;
    assign bus.RegWr_M = info_m_q.reg_wr;
    assign bus.RegWr_W = info_w_q.reg_wr;
    assign bus.Tnew_E  = info_e_q.tnew;
    assign bus.Tnew_M  = info_m_q.tnew;

endmodule

// File: tb/tb_hazard_info_pipe.sv
// tb_hazard_info_pipe: directed and randomized self-checking bench for hazard_info_pipe.
// Reference model: three stage records updated per clock from the instruction rules.
// Honours LOAD_EXT_EN the same way the design build does.
module tb_hazard_info_pipe;

`ifdef LOAD_EXT_EN
    localparam bit LoadExt = 1'b1;
`else
    localparam bit LoadExt = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hazard_info_pipe_if #(.WIDTH(32)) bus ();

    hazard_info_pipe #(
        .WIDTH    (32),
        .RA_REG   (31),
        .TNEW_LOAD(2),
        .TNEW_ALU (1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  a3;
        logic        wr;
        int          tnew;
        logic [31:0] instr;
        logic [31:0] pc8;
    } rec_t;

    rec_t me, mm, mw;

    function automatic rec_t bubble();
        rec_t r;
        r.a1 = 0; r.a2 = 0; r.a3 = 0; r.wr = 0; r.tnew = 0; r.instr = 0; r.pc8 = 0;
        return r;
    endfunction

    // What an instruction entering E should look like
    function automatic rec_t model_decode(logic [31:0] ins, logic [31:0] pc);
        rec_t       r;
        logic [5:0] op;
        logic [5:0] fn;
        bit         is_load;
        op = ins[31:26];
        fn = ins[5:0];
        r = bubble();
        r.a1    = ins[25:21];
        r.a2    = ins[20:16];
        r.instr = ins;
        r.pc8   = pc + 32'd8;
        is_load = (op == 6'h23) ||
                  (LoadExt && (op == 6'h20 || op == 6'h21 || op == 6'h24 || op == 6'h25));
        if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) begin
            r.a3 = ins[15:11]; r.tnew = 1;
        end else if (op == 6'h0d || op == 6'h0f) begin
            r.a3 = ins[20:16]; r.tnew = 1;
        end else if (is_load) begin
            r.a3 = ins[20:16]; r.tnew = 2;
        end else if (op == 6'h03) begin
            r.a3 = 5'd31; r.tnew = 0;
        end
        r.wr = (r.a3 != 0);
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string ctx);
        check_eq({ctx, ":instr_E"}, bus.instr_E, me.instr);
        check_eq({ctx, ":instr_M"}, bus.instr_M, mm.instr);
        check_eq({ctx, ":instr_W"}, bus.instr_W, mw.instr);
        check_eq({ctx, ":pc8_E"}, bus.pc8_E, me.pc8);
        check_eq({ctx, ":pc8_M"}, bus.pc8_M, mm.pc8);
        check_eq({ctx, ":pc8_W"}, bus.pc8_W, mw.pc8);
        check_eq({ctx, ":A1_E"}, 32'(bus.A1_E), 32'(me.a1));
        check_eq({ctx, ":A2_E"}, 32'(bus.A2_E), 32'(me.a2));
        check_eq({ctx, ":A2_M"}, 32'(bus.A2_M), 32'(mm.a2));
        check_eq({ctx, ":A3_E"}, 32'(bus.A3_E), 32'(me.a3));
        check_eq({ctx, ":A3_M"}, 32'(bus.A3_M), 32'(mm.a3));
        check_eq({ctx, ":A3_W"}, 32'(bus.A3_W), 32'(mw.a3));
        check_eq({ctx, ":RegWr_E"}, 32'(bus.RegWr_E), 32'(me.wr));
        check_eq({ctx, ":RegWr_M"}, 32'(bus.RegWr_M), 32'(mm.wr));
        check_eq({ctx, ":RegWr_W"}, 32'(bus.RegWr_W), 32'(mw.wr));
        check_eq({ctx, ":Tnew_E"}, 32'(bus.Tnew_E), 32'(me.tnew));
        check_eq({ctx, ":Tnew_M"}, 32'(bus.Tnew_M), 32'(mm.tnew));
    endtask

    // Drive one D-stage cycle, advance the model at the edge, check just after it
    task automatic step(input logic [31:0] ins, input logic [31:0] pc,
                        input bit st, input bit fl, input string ctx);
        bus.instr_D = ins;
        bus.pc_D    = pc;
        bus.stall   = st;
        bus.flush_E = fl;
        @(posedge clk);
        mw = mm;
        mm = me;
        mm.tnew = (me.tnew > 0) ? me.tnew - 1 : 0;
        me = (st || fl) ? bubble() : model_decode(ins, pc);
        #1;
        check_all(ctx);
        @(negedge clk);
    endtask

    // Pulse reset between edges; outputs must clear before the next edge
    task automatic async_reset(input string ctx);
        #2;
        reset = 1'b1;
        #1;
        me = bubble(); mm = bubble(); mw = bubble();
        check_all(ctx);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [10];
        logic [5:0] fns [4];
        logic [5:0] op;
        logic [5:0] fn;
        int         k;
        ops = '{6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03, 6'h20, 6'h25, 6'h29};
        fns = '{6'h21, 6'h23, 6'h08, 6'h00};
        k = $urandom_range(0, 13);
        if (k < 10) begin
            op = ops[k];
            fn = 6'($urandom);
        end else if (k < 12) begin
            op = 6'h00;
            fn = fns[$urandom_range(0, 3)];
        end else begin
            op = 6'($urandom);
            fn = 6'($urandom);
        end
        return {op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), fn};
    endfunction

    logic [31:0] lw_8_9;
    logic [31:0] addu_3;
    logic [31:0] jal_i;
    logic [31:0] ori_0;
    logic [31:0] lb_5_6;

    initial begin
        lw_8_9 = {6'h23, 5'd9, 5'd8, 16'h0000};
        addu_3 = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
        jal_i  = {6'h03, 26'h0000c00};
        ori_0  = {6'h0d, 5'd1, 5'd0, 16'h0005};
        lb_5_6 = {6'h20, 5'd6, 5'd5, 16'h0000};

        bus.instr_D = '0;
        bus.pc_D    = '0;
        bus.stall   = 1'b0;
        bus.flush_E = 1'b0;
        reset       = 1'b1;
        me = bubble(); mm = bubble(); mw = bubble();
        @(negedge clk);
        check_all("reset");
        reset = 1'b0;

        // lw latency through the stages
        step(lw_8_9, 32'h1000, 0, 0, "lw1");
        check_eq("lw_A3_E", 32'(bus.A3_E), 32'd8);
        check_eq("lw_RegWr_E", 32'(bus.RegWr_E), 32'd1);
        check_eq("lw_Tnew_E", 32'(bus.Tnew_E), 32'd2);
        check_eq("lw_A1_E", 32'(bus.A1_E), 32'd9);
        step(32'h0, 32'h1004, 0, 0, "lw2");
        check_eq("lw_A3_M", 32'(bus.A3_M), 32'd8);
        check_eq("lw_Tnew_M", 32'(bus.Tnew_M), 32'd1);
        step(32'h0, 32'h1008, 0, 0, "lw3");
        check_eq("lw_A3_W", 32'(bus.A3_W), 32'd8);
        check_eq("lw_RegWr_W", 32'(bus.RegWr_W), 32'd1);

        // asynchronous reset with loads in E and M
        step(lw_8_9, 32'h2000, 0, 0, "rst_a");
        step(lw_8_9, 32'h2004, 0, 0, "rst_b");
        async_reset("async_rst");
        check_eq("rst_A3_M", 32'(bus.A3_M), 32'd0);
        check_eq("rst_RegWr_E", 32'(bus.RegWr_E), 32'd0);

        // addu followed by a stall cycle
        step(addu_3, 32'h3000, 0, 0, "addu");
        step(lw_8_9, 32'h3004, 1, 0, "stall");
        check_eq("stall_A3_E", 32'(bus.A3_E), 32'd0);
        check_eq("stall_RegWr_E", 32'(bus.RegWr_E), 32'd0);
        check_eq("stall_Tnew_E", 32'(bus.Tnew_E), 32'd0);
        check_eq("stall_A3_M", 32'(bus.A3_M), 32'd3);
        check_eq("stall_Tnew_M", 32'(bus.Tnew_M), 32'd0);

        // jal link value and destination
        step(jal_i, 32'h00003000, 0, 0, "jal");
        check_eq("jal_pc8_E", bus.pc8_E, 32'h00003008);
        check_eq("jal_A3_E", 32'(bus.A3_E), 32'd31);
        check_eq("jal_Tnew_E", 32'(bus.Tnew_E), 32'd0);
        step(32'h0, 32'h3004, 0, 0, "jal2");
        step(32'h0, 32'h3008, 0, 0, "jal3");
        check_eq("jal_pc8_W", bus.pc8_W, 32'h00003008);

        // write to $0 and PC wrap
        step(ori_0, 32'hFFFFFFFC, 0, 0, "ori0");
        check_eq("ori0_RegWr_E", 32'(bus.RegWr_E), 32'd0);
        check_eq("ori0_A3_E", 32'(bus.A3_E), 32'd0);
        check_eq("wrap_pc8_E", bus.pc8_E, 32'h00000004);

        // byte load, feature-dependent
        step(lb_5_6, 32'h4000, 0, 0, "lb");
        if (LoadExt) begin
            check_eq("lb_A3_E", 32'(bus.A3_E), 32'd5);
            check_eq("lb_Tnew_E", 32'(bus.Tnew_E), 32'd2);
        end else begin
            check_eq("lb_RegWr_E", 32'(bus.RegWr_E), 32'd0);
            check_eq("lb_A3_E", 32'(bus.A3_E), 32'd0);
        end

        // stall and flush together give one bubble
        step(lw_8_9, 32'h5000, 1, 1, "stall_flush");
        check_eq("sf_A3_E", 32'(bus.A3_E), 32'd0);
        check_eq("sf_instr_E", bus.instr_E, 32'd0);

        // randomized stream
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                async_reset("rnd_rst");
            end
            step(rand_instr(), $urandom, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
